// File: rtl/aw_vpu_scanout_if.sv
// aw_vpu_scanout_if
// Groups the framebuffer fetch port and the host-side control strobes of the
// scanout block into one bundle.
//   fb_rd / fb_addr : read strobe and {page, pixel index} towards framebuffer
//   fb_data         : colour index returned one cycle after fb_rd
//   pal_we/idx/data : shadow palette write port
//   pal_commit      : request shadow-to-active palette copy at next vblank
//   swap_req        : request front-page toggle at next vblank
//   swap_ack        : one-cycle pulse when a page swap is applied
// The master modport is the scanout side; slave is the memory/host side.
interface aw_vpu_scanout_if #(
  parameter int ADDR_W     = 16,
  parameter int COLOR_BITS = 4
);
  logic                      fb_rd;
  logic [ADDR_W:0]           fb_addr;
  logic [3:0]                fb_data;
  logic                      pal_we;
  logic [3:0]                pal_idx;
  logic [3*COLOR_BITS-1:0]   pal_data;
  logic                      pal_commit;
  logic                      swap_req;
  logic                      swap_ack;

  modport master (
    output fb_rd, fb_addr, swap_ack,
    input  fb_data, pal_we, pal_idx, pal_data, pal_commit, swap_req
  );

  modport slave (
    input  fb_rd, fb_addr, swap_ack,
    output fb_data, pal_we, pal_idx, pal_data, pal_commit, swap_req
  );
endinterface

// File: rtl/aw_vpu_scanout.sv
// aw_vpu_scanout
// Video scanout: programmable sync timing, integer-scaled fetch of 4-bit
// indexed pixels from a double-buffered framebuffer, 16-entry palette with
// shadow/commit, page swap at vblank and an hpos[5]/vpos[5] bar test mode.
// Ports:
//   clk, reset     : pixel clock, synchronous active-high reset
//   test_mode      : 1 selects the bar pattern instead of framebuffer pixels
//   bus            : framebuffer fetch + palette/swap control (master side)
//   vblank_start   : one-cycle pulse after each frame boundary
//   front_page     : page currently scanned out
//   hsync, vsync   : sync outputs (polarity set by SYNC_NEG)
//   display_on     : inside the active area
//   rgb            : {b,g,r}
// Pipeline: counters -> registered fetch -> fb_data returns -> registered
// outputs, so video outputs lag the counter by three cycles.
module aw_vpu_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_NEG   = 1,
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 200,
  parameter int SCALE      = 2,
  parameter int H_OFFSET   = 0,
  parameter int V_OFFSET   = 40,
  parameter int ADDR_W     = 16,
  parameter int COLOR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    test_mode,
  aw_vpu_scanout_if.master        bus,
  output logic                    vblank_start,
  output logic                    front_page,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    display_on,
  output logic [3*COLOR_BITS-1:0] rgb
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int SW        = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int HS_START  = H_ACTIVE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;
  localparam int IMG_H_END = H_OFFSET + SCALE * SRC_W;
  localparam int IMG_V_END = V_OFFSET + SCALE * SRC_H;
  localparam logic SYNC_POL = (SYNC_NEG != 0) ? 1'b1 : 1'b0;
  localparam int CB        = COLOR_BITS;

  typedef struct packed {
    logic active;
    logic img;
    logic test;
    logic hbit;
    logic vbit;
    logic hs;
    logic vs;
  } ctl_t;

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [31:0]       h32;
  logic [31:0]       v32;
  logic              h_last, v_last;
  logic              in_img_h, in_img_v, in_img, in_active;
  logic              boundary;
  logic [SW-1:0]     x_sub, y_sub;
  logic [ADDR_W-1:0] pix_idx, line_base;
  logic              swap_pend, commit_pend;
  logic [3*CB-1:0]   shadow_pal [16];
  logic [3*CB-1:0]   active_pal [16];
  ctl_t              s1, s2;

  // Decode the current counter position into the regions used downstream.
  always_comb begin
    h32       = 32'(h);
    v32       = 32'(v);
    h_last    = (h32 == 32'(H_TOTAL - 1));
    v_last    = (v32 == 32'(V_TOTAL - 1));
    in_img_h  = (h32 >= 32'(H_OFFSET)) && (h32 < 32'(IMG_H_END));
    in_img_v  = (v32 >= 32'(V_OFFSET)) && (v32 < 32'(IMG_V_END));
    in_img    = in_img_h && in_img_v;
    in_active = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
    boundary  = (h32 == 32'd0) && (v32 == 32'(V_ACTIVE));
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Incremental pixel index: x_sub/y_sub count replicas of a source pixel or
  // row, line_base is the index of the first pixel of the current source row,
  // and pix_idx is reloaded from it at every line end.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_sub     <= '0;
      y_sub     <= '0;
      pix_idx   <= '0;
      line_base <= '0;
    end else if (h_last) begin
      x_sub <= '0;
      if (v_last) begin
        y_sub     <= '0;
        line_base <= '0;
        pix_idx   <= '0;
      end else if (in_img_v) begin
        if (y_sub == SW'(SCALE - 1)) begin
          y_sub     <= '0;
          line_base <= line_base + ADDR_W'(SRC_W);
          pix_idx   <= line_base + ADDR_W'(SRC_W);
        end else begin
          y_sub   <= y_sub + SW'(1);
          pix_idx <= line_base;
        end
      end else begin
        pix_idx <= line_base;
      end
    end else if (in_img_h) begin
      if (x_sub == SW'(SCALE - 1)) begin
        x_sub   <= '0;
        pix_idx <= pix_idx + ADDR_W'(1);
      end else begin
        x_sub <= x_sub + SW'(1);
      end
    end
  end

  // Fetch stage plus the two-deep control pipeline that keeps sync and
  // region flags aligned with the returning fb_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.fb_rd   <= 1'b0;
      bus.fb_addr <= '0;
      s1          <= '0;
      s2          <= '0;
    end else begin
      bus.fb_rd   <= in_img && !test_mode;
      bus.fb_addr <= {front_page, pix_idx};
      s1.active   <= in_active;
      s1.img      <= in_img;
      s1.test     <= test_mode;
      s1.hbit     <= h32[5];
      s1.vbit     <= v32[5];
      s1.hs       <= (h32 >= 32'(HS_START)) && (h32 < 32'(HS_END));
      s1.vs       <= (v32 >= 32'(VS_START)) && (v32 < 32'(VS_END));
      s2          <= s1;
    end
  end

  // Palette and page state. At the boundary the copy and toggle use the
  // pending flags from before this cycle; requests arriving on the boundary
  // cycle reload the flags so they take effect one frame later, and a shadow
  // write on that cycle is not seen by the copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_page   <= 1'b0;
      swap_pend    <= 1'b0;
      commit_pend  <= 1'b0;
      bus.swap_ack <= 1'b0;
      vblank_start <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        shadow_pal[i] <= '0;
        active_pal[i] <= '0;
      end
    end else begin
      if (bus.pal_we) begin
        shadow_pal[bus.pal_idx] <= bus.pal_data;
      end
      if (boundary) begin
        vblank_start <= 1'b1;
        bus.swap_ack <= swap_pend;
        if (swap_pend) begin
          front_page <= ~front_page;
        end
        if (commit_pend) begin
          for (int i = 0; i < 16; i++) begin
            active_pal[i] <= shadow_pal[i];
          end
        end
        swap_pend   <= bus.swap_req;
        commit_pend <= bus.pal_commit;
      end else begin
        vblank_start <= 1'b0;
        bus.swap_ack <= 1'b0;
        swap_pend    <= swap_pend | bus.swap_req;
        commit_pend  <= commit_pend | bus.pal_commit;
      end
    end
  end

  // Output stage: palette lookup straight from fb_data, bar pattern, or
  // blanking, registered together with the delayed sync flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync      <= SYNC_POL;
      vsync      <= SYNC_POL;
      display_on <= 1'b0;
      rgb        <= '0;
    end else begin
      hsync      <= s2.hs ^ SYNC_POL;
      vsync      <= s2.vs ^ SYNC_POL;
      display_on <= s2.active;
      if (!s2.active) begin
        rgb <= '0;
      end else if (s2.test) begin
        rgb <= {{CB{s2.hbit}}, {CB{1'b0}}, {CB{s2.vbit}}};
      end else if (s2.img) begin
        rgb <= active_pal[bus.fb_data];
      end else begin
        rgb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aw_vpu_scanout.sv
// tb_aw_vpu_scanout
// Drives aw_vpu_scanout with a reduced raster (56 x 47 clocks per frame) and
// compares every cycle against a behavioural model that computes positions,
// pixel indices and colours directly from raster arithmetic. A set of
// hand-computed literal checks pins sync timing, fetch addressing, palette,
// swap, boundary collisions, test mode and mid-frame reset.
module tb_aw_vpu_scanout;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VSY = 2, VBP = 3;
  localparam int SRCW = 16, SRCH = 12, S = 2, HO = 4, VO = 6;
  localparam int AW = 8, CB = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;
  localparam int BND = HT * VA;

  logic          clk, reset, test_mode;
  logic          vblank_start, front_page, hsync, vsync, display_on;
  logic [11:0]   rgb;
  logic [3:0]    mem [0:511];

  int checks = 0;
  int errors = 0;

  aw_vpu_scanout_if #(.ADDR_W(AW), .COLOR_BITS(CB)) bus();

  aw_vpu_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_NEG(1), .SRC_W(SRCW), .SRC_H(SRCH), .SCALE(S),
    .H_OFFSET(HO), .V_OFFSET(VO), .ADDR_W(AW), .COLOR_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .test_mode(test_mode), .bus(bus),
    .vblank_start(vblank_start), .front_page(front_page),
    .hsync(hsync), .vsync(vsync), .display_on(display_on), .rgb(rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer memory with one cycle of read latency; junk when not read.
  always @(posedge clk) begin
    if (bus.fb_rd) bus.fb_data <= mem[bus.fb_addr];
    else           bus.fb_data <= 4'($urandom);
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit       active;
    bit       img;
    bit       test;
    bit       hb;
    bit       vb;
    bit       hs;
    bit       vs;
    bit [8:0] addr;
  } pix_t;

  int        kcnt = 0;
  bit        model_live = 0;
  bit [11:0] m_shadow [16];
  bit [11:0] m_active [16];
  bit        m_swap_pend, m_commit_pend, m_front;
  pix_t      pq[$];
  bit        e_rd, e_ack, e_vb, e_front, e_hs, e_vsync, e_disp;
  bit [8:0]  e_addr;
  bit [11:0] e_rgb;

  always @(posedge clk) begin : model
    int   h, v, idx;
    pix_t p, q;
    if (reset) begin
      model_live = 1;
      kcnt = 0;
      pq.delete();
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_swap_pend = 0; m_commit_pend = 0; m_front = 0;
      e_rd = 0; e_addr = 0; e_ack = 0; e_vb = 0; e_front = 0;
      e_hs = 1; e_vsync = 1; e_disp = 0; e_rgb = 0;
    end else begin
      h = kcnt % HT;
      v = (kcnt / HT) % VT;
      p.active = (h < HA) && (v < VA);
      p.img    = (h >= HO) && (h < HO + S * SRCW) && (v >= VO) && (v < VO + S * SRCH);
      p.test   = test_mode;
      p.hb     = ((h / 32) % 2) == 1;
      p.vb     = ((v / 32) % 2) == 1;
      p.hs     = (h >= HA + HFP) && (h < HA + HFP + HSY);
      p.vs     = (v >= VA + VFP) && (v < VA + VFP + VSY);
      idx      = p.img ? ((v - VO) / S) * SRCW + (h - HO) / S : 0;
      p.addr   = {m_front, 8'(idx)};
      e_rd     = p.img && !test_mode;
      e_addr   = p.addr;
      pq.push_back(p);
      if (pq.size() == 3) begin
        q = pq.pop_front();
        e_disp  = q.active;
        e_hs    = !q.hs;
        e_vsync = !q.vs;
        if (!q.active)   e_rgb = 12'h000;
        else if (q.test) e_rgb = {{4{q.hb}}, 4'h0, {4{q.vb}}};
        else if (q.img)  e_rgb = m_active[mem[q.addr]];
        else             e_rgb = 12'h000;
      end else begin
        e_disp = 0; e_hs = 1; e_vsync = 1; e_rgb = 0;
      end
      if (h == 0 && v == VA) begin
        e_vb  = 1;
        e_ack = m_swap_pend;
        if (m_swap_pend) m_front = !m_front;
        if (m_commit_pend) m_active = m_shadow;
        m_swap_pend   = bus.swap_req;
        m_commit_pend = bus.pal_commit;
      end else begin
        e_vb = 0;
        e_ack = 0;
        m_swap_pend   = m_swap_pend | bus.swap_req;
        m_commit_pend = m_commit_pend | bus.pal_commit;
      end
      if (bus.pal_we) m_shadow[bus.pal_idx] = bus.pal_data;
      e_front = m_front;
      kcnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t cycle=%0d: got %h expected %h", name, $time, kcnt, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [27:0] act, exp;
    if (model_live) begin
      act = {bus.fb_rd, bus.fb_rd ? bus.fb_addr : 9'd0, bus.swap_ack, vblank_start,
             front_page, hsync, vsync, display_on, rgb};
      exp = {e_rd, e_rd ? e_addr : 9'd0, e_ack, e_vb, e_front, e_hs, e_vsync, e_disp, e_rgb};
      checkOutput("cycle", 32'(act), 32'(exp));
    end
  end

  // Wait (at negedges) until the visible cycle index reaches target.
  task automatic waitVis(input int target);
    int guard = 0;
    while (kcnt != target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (kcnt != target) checkOutput("wait_bound", 32'(kcnt), 32'(target));
  endtask

  // Present the given strobes so the DUT samples them at edge k only.
  task automatic applyStimulus(input int k, input bit sw, input bit cm, input bit we,
                               input logic [3:0] idx, input logic [11:0] data);
    waitVis(k);
    bus.swap_req = sw; bus.pal_commit = cm; bus.pal_we = we;
    bus.pal_idx = idx; bus.pal_data = data;
    waitVis(k + 1);
    bus.swap_req = 0; bus.pal_commit = 0; bus.pal_we = 0;
  endtask

  initial begin
    int first_low, lows, acks, rdc, k, kb;
    reset = 1; test_mode = 0;
    bus.swap_req = 0; bus.pal_commit = 0; bus.pal_we = 0;
    bus.pal_idx = 0; bus.pal_data = 0;
    for (int i = 0; i < 512; i++) mem[i] = 4'($urandom);
    mem[0] = 4'd5;
    repeat (3) @(negedge clk);
    reset = 0;

    // Sync timing: hsync low from cycle 47 for 6 cycles.
    first_low = -1; lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!hsync) begin
        if (first_low < 0) first_low = kcnt;
        lows++;
      end
    end
    checkOutput("hsync_first_low", 32'(first_low), 32'd47);
    checkOutput("hsync_width", 32'(lows), 32'd6);

    // Frame 0: palette writes and commit.
    applyStimulus(100, 0, 0, 1, 4'd5, 12'hABC);
    for (int i = 0; i < 5; i++)
      applyStimulus(110 + 2 * i, 0, 0, 1, 4'($urandom_range(6, 15)), 12'($urandom));
    applyStimulus(130, 0, 1, 0, 4'd0, 12'h000);
    waitVis(341);
    checkOutput("first_fetch", {bus.fb_rd, bus.fb_addr}, {1'b1, 9'd0});
    waitVis(343);
    checkOutput("rgb_before_commit", {display_on, rgb}, {1'b1, 12'h000});
    waitVis(1660);
    checkOutput("last_fetch", {bus.fb_rd, bus.fb_addr}, {1'b1, 9'd191});
    waitVis(1661);
    checkOutput("after_last_fetch", 32'(bus.fb_rd), 32'd0);
    waitVis(BND + 1);
    checkOutput("vblank_pulse", 32'(vblank_start), 32'd1);

    // Frame 1: committed colour, then triple swap request.
    waitVis(FR + 343);
    checkOutput("rgb_entry5", 32'(rgb), 32'h00000ABC);
    applyStimulus(FR + 500, 1, 0, 0, 4'd0, 12'h000);
    applyStimulus(FR + 600, 1, 0, 0, 4'd0, 12'h000);
    applyStimulus(FR + 700, 1, 0, 0, 4'd0, 12'h000);
    acks = 0;
    while (kcnt < FR + 2300) begin
      @(negedge clk);
      if (bus.swap_ack) acks++;
    end
    checkOutput("swap_ack_count", 32'(acks), 32'd1);
    checkOutput("front_after_swap", 32'(front_page), 32'd1);

    // Frame 2: fetches from page 1.
    waitVis(2 * FR + 341);
    checkOutput("page1_fetch", {bus.fb_rd, bus.fb_addr}, {1'b1, 9'h100});

    // Frame 3: collisions on the boundary cycle.
    applyStimulus(3 * FR + 200, 0, 0, 1, 4'd7, 12'h123);
    applyStimulus(3 * FR + 210, 0, 1, 0, 4'd0, 12'h000);
    kb = 3 * FR + BND;
    applyStimulus(kb, 1, 1, 1, 4'd7, 12'h456);
    checkOutput("bnd_no_ack", {bus.swap_ack, vblank_start, front_page}, 3'b011);
    checkOutput("model_pal7_old", 32'(m_active[7]), 32'h123);
    waitVis(kb + FR + 1);
    checkOutput("deferred_swap", {bus.swap_ack, front_page}, 2'b10);
    checkOutput("model_pal7_new", 32'(m_active[7]), 32'h456);

    // Frames 5-6: randomized traffic.
    k = 5 * FR;
    while (k < 7 * FR - 300) begin
      test_mode = ($urandom_range(0, 5) == 0);
      applyStimulus(k, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1, 4'($urandom), 12'($urandom));
      k += $urandom_range(20, 300);
    end
    test_mode = 0;

    // Frame 7: test pattern.
    waitVis(7 * FR);
    test_mode = 1;
    rdc = 0;
    while (kcnt < 7 * FR + 33 * HT + 10 + 3) begin
      @(negedge clk);
      if (bus.fb_rd) rdc++;
    end
    checkOutput("tm_no_fetch", 32'(rdc), 32'd0);
    checkOutput("tm_red_bar", 32'(rgb), 32'h0000000F);
    waitVis(7 * FR + 33 * HT + 33 + 3);
    checkOutput("tm_red_blue", 32'(rgb), 32'h00000F0F);
    waitVis(8 * FR);
    test_mode = 0;

    // Frame 8: pending swap, then reset at (30,20).
    applyStimulus(8 * FR + 100, 1, 1, 0, 4'd0, 12'h000);
    waitVis(8 * FR + 20 * HT + 30);
    reset = 1;
    @(negedge clk);
    checkOutput("reset_outputs",
                {bus.fb_rd, bus.swap_ack, vblank_start, front_page, hsync, vsync, display_on, rgb},
                {7'b0000110, 12'h000});
    reset = 0;
    waitVis(BND + 1);
    checkOutput("reset_drops_pending", {bus.swap_ack, vblank_start, front_page}, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aw_vpu_scanout.md
# aw_vpu_scanout

Parametrised video scanout for the Another World video path. It generates programmable sync timing and fetches 4-bit indexed pixels from a double-buffered framebuffer memory. Pixels are integer-scaled into the active area and translated through a 16-entry palette with shadow/commit semantics. It adds page swapping at vblank and keeps the `hpos[5]`/`vpos[5]` bar test pattern as a selectable mode.

## Interface

**Parameters**

- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, `H_SYNC`, `H_BP`, 16/96/48: horizontal front porch, sync and back porch widths.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, `V_SYNC`, `V_BP`, 10/2/33: vertical front porch, sync and back porch heights.
- `SYNC_NEG`, 1: 1 means the sync pulses are active-low.
- `SRC_W`, `SRC_H`, 320/200: source image size in framebuffer pixels.
- `SCALE`, 2: integer pixel and line replication factor, ≥1.
- `H_OFFSET`, `V_OFFSET`, 0/40: top-left output position of the scaled image.
- `ADDR_W`, 16: pixel-index width; must satisfy 2^ADDR_W ≥ `SRC_W*SRC_H`.
- `COLOR_BITS`, 4: bits per colour channel.

**Ports** (clock and reset first)

- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `test_mode` in 1: 1 selects the bar pattern instead of framebuffer pixels.
- `fb_rd` out 1: framebuffer read strobe.
- `fb_addr` out `ADDR_W+1`: {page, pixel index}.
- `fb_data` in 4: colour index; valid exactly one cycle after `fb_rd`.
- `pal_we` in 1: shadow palette write enable.
- `pal_idx` in 4: palette entry to write.
- `pal_data` in `3*COLOR_BITS`: {b,g,r} value for the entry.
- `pal_commit` in 1: pulse; request a shadow-to-active palette copy.
- `swap_req` in 1: pulse; request a front-page toggle.
- `swap_ack` out 1: one-cycle pulse when a swap is applied.
- `vblank_start` out 1: one-cycle pulse at each frame boundary.
- `front_page` out 1: page currently scanned out.
- `hsync`, `vsync` out 1: sync outputs.
- `display_on` out 1: inside the active area.
- `rgb` out `3*COLOR_BITS`: {b,g,r}.

## Operation

- **Counters.**
  - `h` runs 0..H_TOTAL-1, with H_TOTAL = sum of the four horizontal parameters.
  - `v` advances when `h` wraps and runs 0..V_TOTAL-1.
  - Both are held at 0 while `reset` is high.
- **Sync.**
  - Hsync is asserted for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - Vsync is asserted for `v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - The output level is inverted when `SYNC_NEG`=1.
- **Image area.** `h` in [H_OFFSET, H_OFFSET+SCALE*SRC_W) and `v` in [V_OFFSET, V_OFFSET+SCALE*SRC_H).
  - Pixel index = ((v-V_OFFSET)/SCALE)*SRC_W + (h-H_OFFSET)/SCALE.
  - Maintain the index incrementally; no divider or multiplier.
  - `fb_rd`=1 only for image-area cycles with `test_mode`=0.
- **Colour selection.**
  - Image area: output the active palette entry for `fb_data`.
  - Active but outside the image: black.
  - Outside the active area: 0.
  - `test_mode`=1 inside the active area: r channel all-ones iff `v[5]`, b channel all-ones iff `h[5]`, g = 0.
- **Palette.**
  - `pal_we` writes the shadow palette only.
  - `pal_commit` sets `commit_pend`.
- **Page swap.** `swap_req` sets `swap_pend`. Repeated requests before the boundary coalesce into one.
- **Frame boundary** (counter at h=0, v=V_ACTIVE):
  - If `swap_pend`, toggle `front_page`.
  - If `commit_pend`, copy shadow to active.
  - Clear both pending flags.
- **Simultaneous events at the boundary cycle.**
  - `swap_req`/`pal_commit` arriving on the boundary cycle are deferred to the next frame.
  - A `pal_we` on the boundary cycle lands in shadow only; the copy uses the pre-write shadow.
- **Reset.**
  - Counters go to 0 and `front_page` to 0.
  - Pending flags are cleared.
  - Both palettes are zeroed.
  - `fb_rd`, `swap_ack` and `vblank_start` go to 0.
  - `rgb` goes to 0 and `display_on` to 0.
  - Hsync/vsync go to their inactive level.
  - A reset mid-frame discards pending requests and restarts at (0,0).

## Timing

- Cycle k = k-th rising edge with `reset` low; the counter during cycle k is (k mod H_TOTAL, k div H_TOTAL mod V_TOTAL).
- Pipeline:
  - Stage 0: counters.
  - Stage 1: `fb_rd`/`fb_addr` registered.
  - Stage 2: `fb_data` captured.
  - Stage 3: palette lookup registered into the outputs.
- `hsync`, `vsync`, `display_on` and `rgb` all reflect the counter value from 3 cycles earlier, and are mutually aligned.
- `fb_rd`/`fb_addr` for counter (h,v) are driven in cycle k+1, where k is the cycle with counter (h,v).
- `swap_ack`, `vblank_start` and the new `front_page` value appear in the cycle after the boundary counter value.
- The palette copy is visible to lookups from that same cycle onward.
- `front_page` is sampled into `fb_addr` per fetch. No fetch occurs between the boundary and the next image line, so no frame tears.

## Test plan

- **Sync timing.** Release reset with defaults → `hsync` low for exactly 96 cycles starting at cycle 659; `vsync` low for lines 490–491; period 800×525 = 420000 cycles.
- **Fetch addressing.** `test_mode`=0, `SCALE`=2 → first `fb_rd` at counter (0,40) with `fb_addr`=0; each index is repeated 2 cycles and each row 2 lines; last fetch at counter (639,439) = 63999; no `fb_rd` outside those bounds.
- **Palette lookup.** Write entry 5 = 0xABC, commit, wait one boundary, return `fb_data`=5 → `rgb`=0xABC exactly 3 cycles after the counter; border pixels (v=20) → 0.
- **Swap.** Pulse `swap_req` 3 times mid-frame → a single toggle at the boundary; `swap_ack` pulses once; the next frame's `fb_addr` MSB = 1.
- **Boundary collisions.** `swap_req` and `pal_commit` on the boundary cycle → applied one frame later. `pal_we` on the boundary cycle while a commit is pending → active palette holds the old shadow value.
- **Test mode and mid-frame reset.** `test_mode`=1 → r all-ones for v=32..63, b all-ones for h=32..63, g=0, `fb_rd` never asserted. Reset at (300,100) → all outputs at reset values next cycle; pending flags lost.
